// File: rtl/dllp_ack_nak_gen.sv
// Ack/Nak DLLP transmit generator: coalesces Acks under a latency timer, sends Naks
// at once (one per episode), and emits each DLLP as a 2-beat AXI-Stream frame with CRC16.
module dllp_ack_nak_gen #(
   parameter int DATA_WIDTH  = 32,
   parameter int KEEP_WIDTH  = DATA_WIDTH/8,
   parameter int USER_WIDTH  = 4,
   parameter int ACK_LATENCY = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            link_status_i,
   input  logic [11:0]           seq_num_i,
   input  logic                  seq_num_vld_i,
   input  logic                  seq_num_acknack_i,
   output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
   output logic                  m_axis_tvalid_o,
   output logic                  m_axis_tlast_o,
   output logic [USER_WIDTH-1:0] m_axis_tuser_o,
   input  logic                  m_axis_tready_i,
   output logic                  ack_pending_o,
   output logic                  nak_scheduled_o
);

   localparam int TW = (ACK_LATENCY < 1) ? 1 : $clog2(ACK_LATENCY + 1);
   localparam logic [TW-1:0] LAT = TW'(ACK_LATENCY);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t        state;
   logic          ack_pending;
   logic          nak_scheduled;
   logic          nak_req;
   logic [11:0]   pend_seq;
   logic [11:0]   nak_seq;
   logic [TW-1:0] timer;
   logic [15:0]   crc_q;

   logic        link_up;
   logic        ack_ev;
   logic        nak_ev;
   logic [11:0] ev_nak_seq;
   logic        idle_up;
   logic        launch_nak;
   logic        launch_ack;
   logic [11:0] launch_seq;
   logic [31:0] hdr;
   logic [15:0] crc_next;

   // CRC16 poly 0x100B, seed 0xFFFF, each byte LSB first; complemented and bit-reversed.
   function automatic logic [15:0] crc16(input logic [31:0] d);
      logic [15:0] c;
      logic [15:0] r;
      logic        fb;
      c = 16'hFFFF;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            fb = d[8*b+i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
         end
      end
      c = ~c;
      for (int i = 0; i < 16; i++) r[i] = c[15-i];
      return r;
   endfunction

   assign link_up    = (link_status_i == 2'b10);
   assign ack_ev     = seq_num_vld_i & seq_num_acknack_i;
   assign nak_ev     = seq_num_vld_i & ~seq_num_acknack_i & ~nak_scheduled;
   assign ev_nak_seq = seq_num_i - 12'd1;
   assign idle_up    = (state == IDLE) && link_up;
   // A fresh Nak event launches in the same cycle so the DLLP is valid one cycle later.
   assign launch_nak = idle_up && (nak_req || nak_ev);
   assign launch_ack = idle_up && !launch_nak && ack_pending && (timer == LAT);
   assign launch_seq = launch_nak ? (nak_ev ? ev_nak_seq : nak_seq) : pend_seq;
   assign hdr        = {launch_seq[7:0], 4'h0, launch_seq[11:8], 8'h00,
                        launch_nak ? 8'h10 : 8'h00};
   assign crc_next   = crc16(hdr);

   assign m_axis_tuser_o  = '0;
   assign ack_pending_o   = ack_pending;
   assign nak_scheduled_o = nak_scheduled;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         ack_pending     <= 1'b0;
         nak_scheduled   <= 1'b0;
         nak_req         <= 1'b0;
         pend_seq        <= '0;
         nak_seq         <= '0;
         timer           <= '0;
         crc_q           <= '0;
         m_axis_tdata_o  <= '0;
         m_axis_tkeep_o  <= '0;
         m_axis_tvalid_o <= 1'b0;
         m_axis_tlast_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch_nak || launch_ack) begin
                  state           <= BEAT0;
                  m_axis_tdata_o  <= DATA_WIDTH'(hdr);
                  m_axis_tkeep_o  <= KEEP_WIDTH'(4'hF);
                  m_axis_tlast_o  <= 1'b0;
                  m_axis_tvalid_o <= 1'b1;
                  crc_q           <= crc_next;
               end
            end
            BEAT0: begin
               if (m_axis_tready_i) begin
                  state          <= BEAT1;
                  m_axis_tdata_o <= DATA_WIDTH'({16'h0000, crc_q});
                  m_axis_tkeep_o <= KEEP_WIDTH'(4'h3);
                  m_axis_tlast_o <= 1'b1;
               end
            end
            BEAT1: begin
               if (m_axis_tready_i) begin
                  state           <= IDLE;
                  m_axis_tdata_o  <= '0;
                  m_axis_tkeep_o  <= '0;
                  m_axis_tlast_o  <= 1'b0;
                  m_axis_tvalid_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Later assignments win: a same-cycle Ack event overrides a launch's clear.
         if ((state == IDLE) && !link_up) begin
            ack_pending <= 1'b0;
            nak_req     <= 1'b0;
         end else begin
            if (launch_nak) begin
               nak_req       <= 1'b0;
               nak_scheduled <= 1'b1;
               ack_pending   <= 1'b0;
            end
            if (launch_ack) ack_pending <= 1'b0;
            if (ack_ev) begin
               pend_seq      <= seq_num_i;
               ack_pending   <= 1'b1;
               nak_scheduled <= 1'b0;
            end else if (nak_ev && !launch_nak) begin
               nak_req <= 1'b1;
               nak_seq <= ev_nak_seq;
            end
         end

         if (((state == IDLE) && !link_up) || launch_nak || launch_ack || !ack_pending)
            timer <= '0;
         else if ((state == IDLE) && (timer != LAT))
            timer <= timer + TW'(1);
      end
   end

endmodule

// File: tb/tb_dllp_ack_nak_gen.sv
// Bench for dllp_ack_nak_gen: directed scenarios plus random traffic, all cycles checked
// against a transaction-level model that queues expected frame beats.
module tb_dllp_ack_nak_gen;
   localparam int LAT = 64;

   logic        clk = 1'b0;
   logic        rst, vld, an, rdy;
   logic [1:0]  link;
   logic [11:0] seq;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid, tlast;
   logic [3:0]  tuser;
   logic        ack_pending, nak_scheduled;

   always #5 clk = ~clk;

   dllp_ack_nak_gen #(.ACK_LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst), .link_status_i(link), .seq_num_i(seq),
      .seq_num_vld_i(vld), .seq_num_acknack_i(an),
      .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep), .m_axis_tvalid_o(tvalid),
      .m_axis_tlast_o(tlast), .m_axis_tuser_o(tuser), .m_axis_tready_i(rdy),
      .ack_pending_o(ack_pending), .nak_scheduled_o(nak_scheduled)
   );

   int n_checks = 0, n_errors = 0, frames = 0;
   logic [31:0] last_b0 = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 50) $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: frames are lists of expected beats; state is plain flags and an age.
   typedef struct {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;
   beat_t       q[$];
   bit          m_pend, m_nakreq, m_naksch;
   logic [11:0] m_pseq, m_nseq;
   int          m_age;

   function automatic logic [15:0] crc_ref(input logic [31:0] w);
      logic [15:0] c, r;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) c = (c << 1) ^ (((w[i] ^ c[15]) != 1'b0) ? 16'h100B : 16'h0000);
      c = ~c;
      for (int i = 0; i < 16; i++) r[i] = c[15-i];
      return r;
   endfunction

   task automatic push_frame(input bit nak, input logic [11:0] s);
      logic [7:0]  b [4];
      logic [31:0] w;
      b[0] = nak ? 8'h10 : 8'h00;
      b[1] = 8'h00;
      b[2] = {4'h0, s[11:8]};
      b[3] = s[7:0];
      w = {b[3], b[2], b[1], b[0]};
      q.push_back('{data: w, keep: 4'hF, last: 1'b0});
      q.push_back('{data: {16'h0000, crc_ref(w)}, keep: 4'h3, last: 1'b1});
   endtask

   task automatic model_step();
      bit          idle, flush, nak_ev, nak_go, ack_go;
      logic [11:0] s, prev;
      if (rst) begin
         q.delete();
         m_pend = 0; m_nakreq = 0; m_naksch = 0; m_age = 0;
         m_pseq = '0; m_nseq = '0;
         return;
      end
      idle = (q.size() == 0);
      if (!idle && rdy) q.delete(0);
      prev   = 12'((int'(seq) + 4095) % 4096);
      flush  = idle && (link != 2'b10);
      nak_ev = vld && !an && !m_naksch;
      nak_go = idle && !flush && (m_nakreq || nak_ev);
      ack_go = idle && !flush && !nak_go && m_pend && (m_age == LAT);
      if (nak_go || ack_go) begin
         s = nak_go ? (nak_ev ? prev : m_nseq) : m_pseq;
         push_frame(nak_go, s);
      end
      if (flush || nak_go || ack_go || !m_pend) m_age = 0;
      else if (idle && m_age < LAT) m_age++;
      if (flush) begin
         m_pend = 0; m_nakreq = 0;
      end else begin
         if (nak_go) begin m_nakreq = 0; m_naksch = 1; m_pend = 0; end
         if (ack_go) m_pend = 0;
         if (vld && an) begin m_pseq = seq; m_pend = 1; m_naksch = 0; end
         else if (nak_ev && !nak_go) begin m_nakreq = 1; m_nseq = prev; end
      end
   endtask

   task automatic tick();
      if (tvalid && tlast && rdy) frames++;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("tvalid", 32'(tvalid), 32'(q.size() > 0));
      chk("tuser", 32'(tuser), 32'h0);
      chk("ack_pending", 32'(ack_pending), 32'(m_pend));
      chk("nak_scheduled", 32'(nak_scheduled), 32'(m_naksch));
      if (q.size() > 0) begin
         chk("tdata", tdata, q[0].data);
         chk("tkeep", 32'(tkeep), 32'(q[0].keep));
         chk("tlast", 32'(tlast), 32'(q[0].last));
      end
      if (tvalid && !tlast) last_b0 = tdata;
      vld = 1'b0;
   endtask

   task automatic ev(input bit a, input logic [11:0] s);
      vld = 1'b1; an = a; seq = s;
      tick();
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n, f0;
      logic [31:0] saved;
      rst = 1'b1; vld = 1'b0; an = 1'b0; seq = '0; rdy = 1'b1; link = 2'b10;
      tick();
      rst = 1'b0;
      chk("reset_tvalid", 32'(tvalid), 32'h0);
      chk("reset_tdata", tdata, 32'h0);
      chk("reset_tkeep", 32'(tkeep), 32'h0);
      chk("reset_tlast", 32'(tlast), 32'h0);

      // Ack latency and frame content
      ev(1'b1, 12'd5);
      n = 0;
      while (!tvalid && n < 200) begin tick(); n++; end
      chk("ack_latency", 32'(n), 32'(LAT + 1));
      chk("ack_b0_data", tdata, 32'h05000000);
      chk("ack_b0_keep", 32'(tkeep), 32'hF);
      tick();
      chk("ack_b1_keep", 32'(tkeep), 32'h3);
      chk("ack_b1_last", 32'(tlast), 32'h1);
      chk("ack_b1_crc", tdata, {16'h0000, crc_ref(32'h05000000)});
      tick();

      // Coalescing
      f0 = frames;
      for (int s = 1; s <= 10; s++) ev(1'b1, 12'(s));
      idle_ticks(150);
      chk("coalesce_frames", 32'(frames - f0), 32'h1);
      chk("coalesce_seq", last_b0, 32'h0A000000);

      // Nak wrap, suppression, new episode
      ev(1'b0, 12'd0);
      chk("nak_next_cycle", 32'(tvalid), 32'h1);
      chk("nak_wrap_data", tdata, 32'hFF0F0010);
      idle_ticks(2);
      f0 = frames;
      ev(1'b0, 12'd9);
      idle_ticks(10);
      chk("nak_suppressed", 32'(frames - f0), 32'h0);
      ev(1'b1, 12'd3);
      ev(1'b0, 12'd8);
      chk("nak_new_episode", tdata, 32'h07000010);
      idle_ticks(2);
      chk("nak_clears_ack", 32'(ack_pending), 32'h0);

      // Backpressure in both beats
      ev(1'b1, 12'd100);
      rdy = 1'b0;
      ev(1'b0, 12'd50);
      saved = tdata;
      chk("stall_b0_hdr", saved, 32'h31000010);
      for (int i = 0; i < 7; i++) begin tick(); chk("stall_b0", tdata, saved); end
      rdy = 1'b1; tick();
      rdy = 1'b0; saved = tdata;
      for (int i = 0; i < 7; i++) begin tick(); chk("stall_b1", tdata, saved); end
      chk("stall_b1_last", 32'(tlast), 32'h1);
      rdy = 1'b1; tick();
      chk("stall_done", 32'(tvalid), 32'h0);

      // Link not active
      ev(1'b1, 12'd7);
      link = 2'b01; tick();
      chk("link_flush", 32'(ack_pending), 32'h0);
      f0 = frames;
      idle_ticks(80);
      chk("link_no_frame", 32'(frames - f0), 32'h0);
      link = 2'b10;
      ev(1'b0, 12'd20);
      link = 2'b01;
      f0 = frames;
      idle_ticks(5);
      chk("link_drop_completes", 32'(frames - f0), 32'h1);
      link = 2'b10;

      // Reset during BEAT1
      ev(1'b1, 12'd1);
      ev(1'b0, 12'd1);
      tick();
      chk("in_beat1", 32'(tlast), 32'h1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_b1_tvalid", 32'(tvalid), 32'h0);
      chk("rst_b1_flags", 32'({ack_pending, nak_scheduled}), 32'h0);

      // Nak and ripe Ack in the same idle cycle
      ev(1'b1, 12'd20);
      idle_ticks(LAT);
      f0 = frames;
      ev(1'b0, 12'd20);
      chk("nak_priority", tdata, 32'h13000010);
      idle_ticks(80);
      chk("nak_priority_frames", 32'(frames - f0), 32'h1);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         rst  = ($urandom_range(0, 299) == 0);
         link = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         vld  = ($urandom_range(0, 3) == 0);
         an   = ($urandom_range(0, 3) != 0);
         seq  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
         rdy  = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
